instr_loader: RTL

//  Program loader upstream of DataPath. Receives a byte stream (count header,

---
 rtl/instr_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Program loader: takes a count header plus MSB-first instruction bytes, writes
// assembled 32-bit words into instruction memory and releases the CPU when done.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  // One bit wider than the address so a full-memory program (cnt == DEPTH) is legal.
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                xfer;
  logic                loading;

  assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign loading    = byte_ready || (state_q == S_WRITE);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    waddr_d     = waddr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) state_d = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (xfer) begin
          cnt_d   = {byte_data, cnt_q[7:0]};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          cnt_d   = {cnt_q[15:8], byte_data};
          waddr_d = '0;
          bidx_d  = '0;
          if (cnt_d == 16'd0 || {1'b0, cnt_d} > DEPTH) state_d = S_ERR;
          else                                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], byte_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr_q;
            mem_wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        waddr_d = waddr_q + 1'b1;
        if (17'(waddr_q) + 17'd1 == {1'b0, cnt_q}) state_d = S_DONE;
        else                                       state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any byte accepted in the same cycle; that byte is dropped.
    if (load_abort && loading) begin
      state_d  = S_IDLE;
      mem_we_d = 1'b0;
    end

    cpu_run_d   = (state_d == S_DONE);
    load_done_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      bidx_q      <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      waddr_q     <= waddr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
